// File: rtl/instr_sequencer_if.sv
// Decoder/fetch-side bundle of the instruction sequencer: control requests in, phase/pc out.
interface instr_sequencer_if #(
    parameter int unsigned PC_W = 11
);
    logic            run;
    logic            ctl_goto;
    logic            ctl_call;
    logic            ctl_return;
    logic            ctl_skip;
    logic [PC_W-1:0] target;
    logic [3:0]      phase;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic            exec_valid;
    logic            stk_overflow;
    logic            stk_underflow;

    // Decoder / test side: drives control, observes sequencing state.
    modport master (
        output run, ctl_goto, ctl_call, ctl_return, ctl_skip, target,
        input  phase, pc, fetch_en, exec_valid, stk_overflow, stk_underflow
    );

    // Sequencer side.
    modport slave (
        input  run, ctl_goto, ctl_call, ctl_return, ctl_skip, target,
        output phase, pc, fetch_en, exec_valid, stk_overflow, stk_underflow
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction-cycle controller: Q1..Q4 phase generator, program counter, circular
// call/return stack and fetch/execute overlap with flush on taken control flow.
module instr_sequencer #(
    parameter int unsigned      PC_W         = 11,
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [PC_W-1:0]  RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.slave   bus
);
    localparam int unsigned    SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W:0]  CNT_FULL = (SP_W + 1)'(STACK_DEPTH);

    typedef enum logic [3:0] {
        StQ1 = 4'b0001,
        StQ2 = 4'b0010,
        StQ3 = 4'b0100,
        StQ4 = 4'b1000
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              exec_valid_q, exec_valid_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_prev;
    logic              cycle_end;
    logic              ctl_ok;

    // Phase register; reset lands in Q1 immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= StQ1;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase sequencing; run is only honoured at the Q1 boundary so a cycle always completes.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            StQ1:    phase_d = bus.run ? StQ2 : StQ1;
            StQ2:    phase_d = StQ3;
            StQ3:    phase_d = StQ4;
            StQ4:    phase_d = StQ1;
            default: phase_d = StQ1;
        endcase
    end

    assign cycle_end = (phase_q == StQ4);
    // A flushed (prefetch-only) cycle carries no real instruction, so its controls are ignored.
    assign ctl_ok    = cycle_end && exec_valid_q;
    assign sp_prev   = sp_q - SP_W'(1);

    // Next pc / stack / flags, committed only on the Q4->Q1 edge.
    always_comb begin
        pc_d         = pc_q;
        exec_valid_d = exec_valid_q;
        sp_d         = sp_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        push         = 1'b0;
        if (cycle_end) begin
            if (ctl_ok && bus.ctl_return) begin
                if (cnt_q == '0) begin
                    pc_d  = RESET_VECTOR;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = stack_q[sp_prev];
                    sp_d  = sp_prev;
                    cnt_d = cnt_q - 1'b1;
                end
                exec_valid_d = 1'b0;
            end else if (ctl_ok && bus.ctl_call) begin
                // pc already holds the return address (the word after the call).
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                if (cnt_q == CNT_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                pc_d         = bus.target;
                exec_valid_d = 1'b0;
            end else if (ctl_ok && bus.ctl_goto) begin
                pc_d         = bus.target;
                exec_valid_d = 1'b0;
            end else if (ctl_ok && bus.ctl_skip) begin
                pc_d         = pc_q + PC_W'(1);
                exec_valid_d = 1'b0;
            end else begin
                pc_d         = pc_q + PC_W'(1);
                exec_valid_d = 1'b1;
            end
        end
    end

    // Sequencing state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_VECTOR;
            exec_valid_q <= 1'b0;
            sp_q         <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            exec_valid_q <= exec_valid_d;
            sp_q         <= sp_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Stack storage; contents are only meaningful below the live count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    assign bus.phase         = phase_q;
    assign bus.pc            = pc_q;
    assign bus.fetch_en      = phase_q[3];
    assign bus.exec_valid    = exec_valid_q;
    assign bus.stk_overflow  = ovf_q;
    assign bus.stk_underflow = unf_q;
endmodule
